// File: rtl/alu_src_arbiter.sv
// alu_src_arbiter
//   Grants the ALU to one of three operand sources (Manual, CPU, UART_RX),
//   steers the operand mux, waits out the ALU latency, captures the result
//   and pulses done back to the granted source.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous reset, active-low
//   req[2:0]   in   requests: [0] Manual, [1] CPU, [2] UART_RX
//   alu_result in   combinational ALU output for the muxed operands
//   mode[1:0]  out  operand-mux select (00 Manual, 01 CPU, 10 UART_RX)
//   grant[2:0] out  one-hot grant, same bit order as req
//   busy       out  high from SETUP through DONE
//   done[2:0]  out  one-cycle pulse to the granted source, result valid then
//   result     out  captured ALU result, held until the next capture
module alu_src_arbiter #(
  parameter int         ALU_LAT   = 1,
  parameter bit         RR_EN     = 1'b1,
  parameter logic [1:0] MODE_IDLE = 2'b01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic [7:0] alu_result,
  output logic [1:0] mode,
  output logic [2:0] grant,
  output logic       busy,
  output logic [2:0] done,
  output logic [7:0] result
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Counter only has to hold ALU_LAT-1.
  localparam int               CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

  logic [1:0]       state;
  logic [1:0]       win;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] lat_cnt;
  logic [1:0]       win_next;

  // Source index successor, modulo 3.
  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    logic [2:0] oh;
    oh = 3'b000;
    case (i)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  // Winner among the set request bits. Round-robin starts the search at ptr;
  // fixed priority lets the lowest index win.
  function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = 2'd0;
    found = 1'b0;
    idx   = ptr;
    if (RR_EN) begin
      for (int k = 0; k < 3; k++) begin
        if (!found && r[idx]) begin
          w     = idx;
          found = 1'b1;
        end
        idx = next_idx(idx);
      end
    end else begin
      if (r[0])      w = 2'd0;
      else if (r[1]) w = 2'd1;
      else if (r[2]) w = 2'd2;
    end
    return w;
  endfunction

  assign win_next = pick_winner(req, rr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode    <= MODE_IDLE;
      grant   <= 3'b000;
      busy    <= 1'b0;
      done    <= 3'b000;
      result  <= 8'h00;
      rr_ptr  <= 2'd0;
      lat_cnt <= '0;
      win     <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 3'b000;
          if (|req) begin
            win   <= win_next;
            grant <= onehot(win_next);
            mode  <= win_next;
            busy  <= 1'b1;
            state <= S_SETUP;
          end
        end

        // One cycle for operands to settle through the mux.
        S_SETUP: begin
          if (!req[win]) begin
            // Abort: source withdrew; pointer still moves on to avoid starvation.
            grant  <= 3'b000;
            busy   <= 1'b0;
            mode   <= MODE_IDLE;
            rr_ptr <= next_idx(win);
            state  <= S_IDLE;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (!req[win]) begin
            grant  <= 3'b000;
            busy   <= 1'b0;
            mode   <= MODE_IDLE;
            rr_ptr <= next_idx(win);
            state  <= S_IDLE;
          end else if (lat_cnt == '0) begin
            result <= alu_result;
            done   <= grant;
            state  <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        // A request still high here is not an abort; it competes again in IDLE.
        S_DONE: begin
          done   <= 3'b000;
          grant  <= 3'b000;
          busy   <= 1'b0;
          mode   <= MODE_IDLE;
          rr_ptr <= next_idx(win);
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_src_arbiter.sv
// tb_alu_src_arbiter
//   Four arbiter instances with different parameters:
//     u0: ALU_LAT=1, round-robin   (table-driven vectors)
//     u1: ALU_LAT=1, fixed priority
//     u2: ALU_LAT=3, round-robin   (abort in EXEC)
//     u3: ALU_LAT=2, round-robin   (moving alu_result, async reset mid-EXEC)
module tb_alu_src_arbiter;

  logic       clk = 1'b0;
  logic       rst_n  [4];
  logic [2:0] req    [4];
  logic [7:0] alu    [4];
  logic [1:0] mode   [4];
  logic [2:0] grant  [4];
  logic       busy   [4];
  logic [2:0] done   [4];
  logic [7:0] result [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_src_arbiter #(.ALU_LAT(1), .RR_EN(1'b1), .MODE_IDLE(2'b01)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .alu_result(alu[0]),
    .mode(mode[0]), .grant(grant[0]), .busy(busy[0]), .done(done[0]), .result(result[0]));
  alu_src_arbiter #(.ALU_LAT(1), .RR_EN(1'b0), .MODE_IDLE(2'b01)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .alu_result(alu[1]),
    .mode(mode[1]), .grant(grant[1]), .busy(busy[1]), .done(done[1]), .result(result[1]));
  alu_src_arbiter #(.ALU_LAT(3), .RR_EN(1'b1), .MODE_IDLE(2'b01)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .req(req[2]), .alu_result(alu[2]),
    .mode(mode[2]), .grant(grant[2]), .busy(busy[2]), .done(done[2]), .result(result[2]));
  alu_src_arbiter #(.ALU_LAT(2), .RR_EN(1'b1), .MODE_IDLE(2'b01)) u3 (
    .clk(clk), .rst_n(rst_n[3]), .req(req[3]), .alu_result(alu[3]),
    .mode(mode[3]), .grant(grant[3]), .busy(busy[3]), .done(done[3]), .result(result[3]));

  typedef struct {
    logic       rst;   // pulse reset before applying this row
    logic [2:0] req;
    logic [7:0] alu;
    logic [1:0] mode;
    logic [2:0] grant;
    logic       busy;
    logic [2:0] done;
    logic [7:0] result;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic rs, input logic [2:0] rq, input logic [7:0] a,
                              input logic [1:0] m, input logic [2:0] g, input logic b,
                              input logic [2:0] d, input logic [7:0] r);
    vec_t v;
    v.rst = rs; v.req = rq; v.alu = a; v.mode = m; v.grant = g;
    v.busy = b; v.done = d; v.result = r;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input int u, input string tag, input logic [1:0] em,
                         input logic [2:0] eg, input logic eb, input logic [2:0] ed,
                         input logic [7:0] er);
    chk({tag, ".mode"},   8'(mode[u]),   8'(em));
    chk({tag, ".grant"},  8'(grant[u]),  8'(eg));
    chk({tag, ".busy"},   8'(busy[u]),   8'(eb));
    chk({tag, ".done"},   8'(done[u]),   8'(ed));
    chk({tag, ".result"}, result[u],     er);
  endtask

  task automatic pulse_reset(input int u);
    rst_n[u] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n[u] = 1'b1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 4; u++) begin
      rst_n[u] = 1'b0;
      req[u]   = 3'b000;
      alu[u]   = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 4; u++)
      chk_out(u, $sformatf("reset_u%0d", u), 2'b01, 3'b000, 1'b0, 3'b000, 8'h00);
    for (int u = 0; u < 4; u++) rst_n[u] = 1'b1;
    step();

    // u0: single CPU transaction, then three RR transactions with all requesting.
    //   rst req     alu    mode   grant   busy  done    result
    add(0, 3'b010, 8'h5A, 2'b01, 3'b010, 1, 3'b000, 8'h00);
    add(0, 3'b010, 8'h5A, 2'b01, 3'b010, 1, 3'b000, 8'h00);
    add(0, 3'b010, 8'h5A, 2'b01, 3'b010, 1, 3'b010, 8'h5A);
    add(0, 3'b010, 8'h5A, 2'b01, 3'b000, 0, 3'b000, 8'h5A);
    add(0, 3'b000, 8'h5A, 2'b01, 3'b000, 0, 3'b000, 8'h5A);
    add(1, 3'b111, 8'h11, 2'b00, 3'b001, 1, 3'b000, 8'h00);
    add(0, 3'b111, 8'h11, 2'b00, 3'b001, 1, 3'b000, 8'h00);
    add(0, 3'b111, 8'h11, 2'b00, 3'b001, 1, 3'b001, 8'h11);
    add(0, 3'b111, 8'h11, 2'b01, 3'b000, 0, 3'b000, 8'h11);
    add(0, 3'b111, 8'h22, 2'b01, 3'b010, 1, 3'b000, 8'h11);
    add(0, 3'b111, 8'h22, 2'b01, 3'b010, 1, 3'b000, 8'h11);
    add(0, 3'b111, 8'h22, 2'b01, 3'b010, 1, 3'b010, 8'h22);
    add(0, 3'b111, 8'h22, 2'b01, 3'b000, 0, 3'b000, 8'h22);
    add(0, 3'b111, 8'h33, 2'b10, 3'b100, 1, 3'b000, 8'h22);
    add(0, 3'b111, 8'h33, 2'b10, 3'b100, 1, 3'b000, 8'h22);
    add(0, 3'b111, 8'h33, 2'b10, 3'b100, 1, 3'b100, 8'h33);
    add(0, 3'b111, 8'h33, 2'b01, 3'b000, 0, 3'b000, 8'h33);
    add(0, 3'b111, 8'h44, 2'b00, 3'b001, 1, 3'b000, 8'h33);

    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset(0);
      req[0] = tbl[i].req;
      alu[0] = tbl[i].alu;
      step();
      chk_out(0, $sformatf("row%0d", i), tbl[i].mode, tbl[i].grant, tbl[i].busy,
              tbl[i].done, tbl[i].result);
    end
    req[0] = 3'b000;

    // u1 fixed priority: CPU beats UART on every transaction.
    req[1] = 3'b110;
    alu[1] = 8'hC3;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("fixed_k%0d.grant", k), 8'(grant[1]),
          (k % 4 == 3) ? 8'h00 : 8'h02);
      chk($sformatf("fixed_k%0d.done", k), 8'(done[1]),
          (k % 4 == 2) ? 8'h02 : 8'h00);
    end
    req[1] = 3'b000;

    // u2 ALU_LAT=3: complete one Manual transaction, then abort a UART one.
    req[2] = 3'b001;
    alu[2] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("lat3_k%0d.done", k), 8'(done[2]), 8'h00);
    end
    step();
    chk_out(2, "lat3_cap", 2'b00, 3'b001, 1'b1, 3'b001, 8'h77);
    step();
    chk_out(2, "lat3_exit", 2'b01, 3'b000, 1'b0, 3'b000, 8'h77);
    req[2] = 3'b100;
    alu[2] = 8'h99;
    step();
    chk_out(2, "abort_grant", 2'b10, 3'b100, 1'b1, 3'b000, 8'h77);
    step();
    step();
    chk_out(2, "abort_exec1", 2'b10, 3'b100, 1'b1, 3'b000, 8'h77);
    req[2] = 3'b000;
    step();
    chk_out(2, "abort_idle", 2'b01, 3'b000, 1'b0, 3'b000, 8'h77);
    req[2] = 3'b111;
    step();
    chk_out(2, "abort_regrant", 2'b00, 3'b001, 1'b1, 3'b000, 8'h77);
    req[2] = 3'b000;

    // u3 ALU_LAT=2: alu_result changes each cycle; capture on 2nd EXEC edge.
    req[3] = 3'b010;
    alu[3] = 8'hA0;
    step();
    chk("mov_grant", 8'(grant[3]), 8'h02);
    alu[3] = 8'hA1;
    step();
    alu[3] = 8'hA2;
    step();
    chk("mov_exec1.done", 8'(done[3]), 8'h00);
    alu[3] = 8'hA3;
    step();
    chk_out(3, "mov_cap", 2'b01, 3'b010, 1'b1, 3'b010, 8'hA3);
    alu[3] = 8'hA4;
    step();
    chk_out(3, "mov_exit", 2'b01, 3'b000, 1'b0, 3'b000, 8'hA3);

    // u3: asynchronous reset while in EXEC.
    step();
    step();
    chk("async_pre.busy", 8'(busy[3]), 8'h01);
    rst_n[3] = 1'b0;
    #1;
    chk_out(3, "async_rst", 2'b01, 3'b000, 1'b0, 3'b000, 8'h00);
    #2;
    rst_n[3] = 1'b1;
    req[3] = 3'b000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
